// File: rtl/grid_scan_if.sv
// Datapath-to-display bundle: grid snapshot inputs and matrix drive outputs.
interface grid_scan_if;
   logic [63:0] grid;
   logic [1:0]  state;
   logic [5:0]  cell_idx;
   logic [7:0]  row_sel;
   logic [7:0]  col_on;
   logic        frame_start;

   modport master (
      output grid, state, cell_idx,
      input  row_sel, col_on, frame_start
   );

   modport slave (
      input  grid, state, cell_idx,
      output row_sel, col_on, frame_start
   );
endinterface

// File: rtl/grid_scan.sv
// Row-multiplexed 8x8 LED driver for the Life grid with per-frame snapshot
// and a blinking cursor overlay while the datapath is programming.
module grid_scan #(
   parameter int ROW_DWELL    = 1024,
   parameter int BLINK_FRAMES = 16
) (
   input logic        clka,
   input logic        rst_n,
   grid_scan_if.slave bus
);

   localparam int DW = $clog2(ROW_DWELL);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DW-1:0] D_LAST = DW'(ROW_DWELL - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

   logic [2:0]    r, r_nx;
   logic [DW-1:0] d, d_nx;
   logic [63:0]   sgrid, sgrid_nx;
   logic [1:0]    sstate, sstate_nx;
   logic [5:0]    sidx, sidx_nx;
   logic          p, p_nx;
   logic [BW-1:0] bc, bc_nx;
   logic          row_end, wrap, snap;
   logic [7:0]    row_bits, cur_mask;
   logic [7:0]    row_sel_nx, col_on_nx;

   always_comb begin
      row_end   = (d == D_LAST);
      wrap      = row_end && (r == 3'd7);
      snap      = (r == 3'd0) && (d == '0);
      d_nx      = row_end ? '0 : d + DW'(1);
      r_nx      = row_end ? r + 3'd1 : r;
      sgrid_nx  = snap ? bus.grid : sgrid;
      sstate_nx = snap ? bus.state : sstate;
      sidx_nx   = snap ? bus.cell_idx : sidx;
      bc_nx     = bc;
      p_nx      = p;
      if (wrap) begin
         if (bc == B_LAST) begin
            bc_nx = '0;
            p_nx  = ~p;
         end else begin
            bc_nx = bc + BW'(1);
         end
      end
      // outputs are registered, so decode from the values the next cycle sees
      row_bits = sgrid_nx[{r_nx, 3'b000} +: 8];
      cur_mask = '0;
      if (sstate_nx == 2'b01 && p_nx && sidx_nx[5:3] == r_nx)
         cur_mask = 8'b1 << sidx_nx[2:0];
      row_sel_nx = '0;
      col_on_nx  = '0;
      if (d_nx >= DW'(2)) begin
         row_sel_nx = 8'b1 << r_nx;
         col_on_nx  = row_bits ^ cur_mask;
      end
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r               <= '0;
         d               <= '0;
         sgrid           <= '0;
         sstate          <= '0;
         sidx            <= '0;
         p               <= 1'b0;
         bc              <= '0;
         bus.row_sel     <= '0;
         bus.col_on      <= '0;
         bus.frame_start <= 1'b0;
      end else begin
         r               <= r_nx;
         d               <= d_nx;
         sgrid           <= sgrid_nx;
         sstate          <= sstate_nx;
         sidx            <= sidx_nx;
         p               <= p_nx;
         bc              <= bc_nx;
         bus.row_sel     <= row_sel_nx;
         bus.col_on      <= col_on_nx;
         bus.frame_start <= wrap;
      end
   end

endmodule
